// File: rtl/param_writer.sv
// param_writer: writes GEMM dims {M,N,K} to param RAM, optionally reads them back, then launches the accelerator
module param_writer #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int VERIFY = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [DATA_W-1:0] cfg_m,
  input  logic [DATA_W-1:0] cfg_n,
  input  logic [DATA_W-1:0] cfg_k,
  output logic              start,
  input  logic              finish,
  output logic              busy,
  output logic              error,
  output logic              cs,
  output logic              oe,
  output logic              w_req,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] w_data,
  input  logic [DATA_W-1:0] r_data
);
  localparam logic CS_ENB = 1'b1, CS_DIS = 1'b0;
  localparam logic OE_ENB = 1'b1, OE_DIS = 1'b0;
  localparam logic WREQ_ENB = 1'b1, WREQ_DIS = 1'b0;
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_VERIFY, S_LAUNCH, S_WAIT, S_ERR} state_t;
  state_t state;
  logic [1:0] step;
  logic [DATA_W-1:0] m, n, k, exp_word;
  logic bad;
  // handshake/status decode and readback compare (read data lags its address by one cycle)
  always_comb begin
    cfg_ready = state == S_IDLE;
    busy = state inside {S_WRITE, S_VERIFY, S_LAUNCH, S_WAIT};
    exp_word = step == 2'd1 ? m : step == 2'd2 ? n : k;
    bad = step != 2'd0 && r_data != exp_word;
  end
  // sequencer with registered RAM-side and launch outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_IDLE;
      step <= '0;
      m <= '0;
      n <= '0;
      k <= '0;
      start <= 1'b0;
      error <= 1'b0;
      cs <= CS_DIS;
      oe <= OE_DIS;
      w_req <= WREQ_DIS;
      addr <= '0;
      w_data <= '0;
    end else begin
      case (state)
        S_IDLE: if (cfg_valid) begin
          state <= S_WRITE;
          step <= '0;
          m <= cfg_m;
          n <= cfg_n;
          k <= cfg_k;
          cs <= CS_ENB;
          w_req <= WREQ_ENB;
          addr <= '0;
          w_data <= cfg_m;
        end
        S_WRITE: begin
          step <= step + 2'd1;
          if (step == 2'd2) begin
            state <= VERIFY != 0 ? S_VERIFY : S_LAUNCH;
            step <= '0;
            cs <= VERIFY != 0 ? CS_ENB : CS_DIS;
            oe <= VERIFY != 0 ? OE_ENB : OE_DIS;
            w_req <= WREQ_DIS;
            addr <= '0;
            w_data <= '0;
            start <= VERIFY == 0;
          end else begin
            addr <= addr + ADDR_W'(1);
            w_data <= step == 2'd0 ? n : k;
          end
        end
        S_VERIFY: begin
          step <= step + 2'd1;
          if (bad) error <= 1'b1;
          if (step == 2'd2) begin
            cs <= CS_DIS;
            oe <= OE_DIS;
            addr <= '0;
          end else if (step != 2'd3) addr <= addr + ADDR_W'(1);
          if (step == 2'd3) begin
            state <= error || bad ? S_ERR : S_LAUNCH;
            start <= !(error || bad);
          end
        end
        S_LAUNCH: begin
          start <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: if (finish) state <= S_IDLE;
        S_ERR: ;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_param_writer.sv
// tb_param_writer: random-job bench comparing a VERIFY=0 and a VERIFY=1 instance against a cycle-rule model
module tb_param_writer;
  logic clk = 0, rstn = 0, cfg_valid = 0, finish = 0, corrupt = 0;
  logic [31:0] cfg_m = 0, cfg_n = 0, cfg_k = 0;
  logic [1:0] cfg_ready, start, busy, error, cs, oe, w_req;
  logic [1:0][31:0] addr, w_data;
  logic [31:0] r0 = 0, r1 = 0;
  logic [31:0] mem0 [4] = '{0, 0, 0, 0};
  logic [31:0] mem1 [4] = '{0, 0, 0, 0};
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  param_writer #(.VERIFY(0)) u_v0 (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .start(start[0]), .finish(finish),
    .busy(busy[0]), .error(error[0]), .cs(cs[0]), .oe(oe[0]), .w_req(w_req[0]),
    .addr(addr[0]), .w_data(w_data[0]), .r_data(r0)
  );
  param_writer #(.VERIFY(1)) u_v1 (
    .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
    .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .start(start[1]), .finish(finish),
    .busy(busy[1]), .error(error[1]), .cs(cs[1]), .oe(oe[1]), .w_req(w_req[1]),
    .addr(addr[1]), .w_data(w_data[1]), .r_data(r1)
  );

  // synchronous single-port RAMs; the second can return 9 for address 1 on reads
  always @(posedge clk) begin
    if (cs[0] && w_req[0]) mem0[addr[0][1:0]] <= w_data[0];
    if (cs[0] && oe[0]) r0 <= mem0[addr[0][1:0]];
  end
  always @(posedge clk) begin
    if (cs[1] && w_req[1]) mem1[addr[1][1:0]] <= w_data[1];
    if (cs[1] && oe[1]) r1 <= (corrupt && addr[1] == 32'd1) ? 32'd9 : mem1[addr[1][1:0]];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // expected outputs c cycles after the accept edge, derived from the job timeline
  task automatic check_cycle(input int i, input int c, input int fin_c, input bit bad, input logic [31:0] w [3]);
    int lc = i == 1 ? 8 : 4;
    bit wr_ph = c >= 1 && c <= 3;
    bit rd_ph = i == 1 && c >= 4 && c <= 6;
    bit err_ph = bad && c >= 8;
    bit bz = c >= 1 && c <= fin_c && !err_ph;
    string s = $sformatf("v%0d_c%0d", i, c);
    if (!(i == 1 && c == 7)) begin
      chk({s, "_cs"}, cs[i], 32'(wr_ph || rd_ph));
      chk({s, "_oe"}, oe[i], 32'(rd_ph));
      chk({s, "_wreq"}, w_req[i], 32'(wr_ph));
      chk({s, "_addr"}, addr[i], wr_ph ? c - 1 : rd_ph ? c - 4 : 0);
      chk({s, "_wdata"}, w_data[i], wr_ph ? w[c-1] : 32'd0);
    end
    chk({s, "_start"}, start[i], 32'(!bad && c == lc));
    chk({s, "_busy"}, busy[i], 32'(bz));
    chk({s, "_ready"}, cfg_ready[i], 32'(!bz && !err_ph));
    if (c <= 6 || c >= 8) chk({s, "_error"}, error[i], 32'(err_ph));
  endtask

  task automatic run_job(input logic [31:0] jm, jn, jk, input bit bad, input bit hold, input int fin_c);
    logic [31:0] w [3];
    w = '{jm, jn, jk};
    corrupt = bad;
    cfg_m = jm;
    cfg_n = jn;
    cfg_k = jk;
    cfg_valid = 1;
    @(posedge clk);
    for (int c = 1; c <= fin_c + 1; c++) begin
      @(negedge clk);
      check_cycle(0, c, fin_c, 0, w);
      check_cycle(1, c, fin_c, bad, w);
      cfg_valid = hold;
      if (hold) begin
        cfg_m = $urandom;
        cfg_n = $urandom;
        cfg_k = $urandom;
      end
      finish = c == fin_c || c == 4;
    end
    finish = 0;
    cfg_valid = 0;
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("mem0_%0d", j), mem0[j], w[j]);
      chk($sformatf("mem1_%0d", j), mem1[j], w[j]);
    end
  endtask

  task automatic do_reset();
    rstn = 0;
    cfg_valid = 0;
    finish = 0;
    corrupt = 0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst%0d_cs", i), cs[i], 0);
      chk($sformatf("rst%0d_oe", i), oe[i], 0);
      chk($sformatf("rst%0d_wreq", i), w_req[i], 0);
      chk($sformatf("rst%0d_addr", i), addr[i], 0);
      chk($sformatf("rst%0d_wdata", i), w_data[i], 0);
      chk($sformatf("rst%0d_start", i), start[i], 0);
      chk($sformatf("rst%0d_busy", i), busy[i], 0);
      chk($sformatf("rst%0d_error", i), error[i], 0);
    end
    rstn = 1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("rel%0d_ready", i), cfg_ready[i], 1);
  endtask

  initial begin
    do_reset();
    finish = 1;
    @(negedge clk);
    finish = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("idle_fin%0d_ready", i), cfg_ready[i], 1);
      chk($sformatf("idle_fin%0d_busy", i), busy[i], 0);
    end
    run_job(32'd4, 32'd8, 32'd16, 0, 0, 20);
    for (int t = 0; t < 8; t++) run_job($urandom, $urandom, $urandom, 0, t[0], int'($urandom_range(10, 25)));
    run_job(32'd4, 32'd8, 32'd16, 1, 0, 20);
    cfg_valid = 1;
    repeat (5) begin
      @(negedge clk);
      chk("err_ready", cfg_ready[1], 0);
      chk("err_start", start[1], 0);
      chk("err_cs", cs[1], 0);
      chk("err_busy", busy[1], 0);
      chk("err_error", error[1], 1);
    end
    cfg_valid = 0;
    do_reset();
    cfg_m = 5;
    cfg_n = 6;
    cfg_k = 7;
    cfg_valid = 1;
    @(negedge clk);
    cfg_valid = 0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) chk($sformatf("mid%0d_addr", i), addr[i], 1);
    #2 rstn = 0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("arst%0d_cs", i), cs[i], 0);
      chk($sformatf("arst%0d_wreq", i), w_req[i], 0);
      chk($sformatf("arst%0d_addr", i), addr[i], 0);
      chk($sformatf("arst%0d_wdata", i), w_data[i], 0);
      chk($sformatf("arst%0d_busy", i), busy[i], 0);
      chk($sformatf("arst%0d_ready", i), cfg_ready[i], 1);
    end
    @(negedge clk);
    rstn = 1;
    repeat (12) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("post%0d_start", i), start[i], 0);
        chk($sformatf("post%0d_busy", i), busy[i], 0);
      end
    end
    run_job(32'd1, 32'd1, 32'd1, 0, 0, 20);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
